// File: rtl/piezo_sequencer.sv
// piezo_sequencer
//   Queues short melody requests (coin / product events) and plays them one at
//   a time on a piezo driver. Each melody is four notes of NOTE_CYCLES clocks
//   each, followed by GAP_CYCLES silent clocks, after which done pulses.
//   Requests are sticky in a pending register and are served lowest index
//   first; a request for a melody already playing queues one replay.
//
// Parameters
//   NOTE_CYCLES  clocks each note index is held (>= 2)
//   GAP_CYCLES   silent clocks after the 4th note (>= 1)
//
// Ports
//   clk          clock, all state updates on posedge
//   rst          asynchronous active-low reset
//   req[6:0]     event pulses: bit0..2 coins 100/500/1000, bit3..6 products 1..4
//   clear        synchronous flush of pending and active melodies
//   note_state   melody code, 0 = none, req bit i -> code i+1
//   note_played  note slot, 0 = silent, 1..4 = note
//   busy         high while a melody plays or sits in its gap
//   done         one-cycle pulse when a melody completes normally

module piezo_sequencer #(
  parameter int unsigned NOTE_CYCLES = 12500000,
  parameter int unsigned GAP_CYCLES  = 2500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] req,
  input  logic       clear,
  output logic [3:0] note_state,
  output logic [2:0] note_played,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic [31:0] NOTE_LAST = 32'(NOTE_CYCLES - 1);
  localparam logic [31:0] GAP_LAST  = 32'(GAP_CYCLES - 1);

  state_t      state_q, state_d;
  logic [6:0]  pending_q, pending_d;
  logic [31:0] cnt_q, cnt_d;
  logic [3:0]  note_state_q, note_state_d;
  logic [2:0]  note_played_q, note_played_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic        grant_valid;
  logic [2:0]  grant_idx;
  logic        note_last;
  logic        gap_last;

  // State register: FSM state plus every registered output and the datapath.
  // Outputs come straight from these flops so req/clear never reach a pin
  // combinationally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      pending_q     <= '0;
      cnt_q         <= '0;
      note_state_q  <= '0;
      note_played_q <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      pending_q     <= pending_d;
      cnt_q         <= cnt_d;
      note_state_q  <= note_state_d;
      note_played_q <= note_played_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  // Next-state logic. The arbiter picks the lowest set pending bit; scanning
  // from the top down leaves the lowest index as the final assignment.
  always_comb begin
    grant_valid = |pending_q;
    grant_idx   = 3'd0;
    for (int i = 6; i >= 0; i--) begin
      if (pending_q[i]) grant_idx = 3'(i);
    end

    note_last = (cnt_q == NOTE_LAST);
    gap_last  = (cnt_q == GAP_LAST);

    state_d = state_q;
    case (state_q)
      IDLE: if (grant_valid) state_d = PLAY;
      PLAY: if (note_last && (note_played_q == 3'd4)) state_d = GAP;
      GAP:  if (gap_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (clear) state_d = IDLE;
  end

  // Output / datapath logic: next values for the registered outputs, the
  // duration counter and the pending flags. The counter restarts at every
  // terminal count, so it never approaches its 32-bit limit.
  always_comb begin
    pending_d     = pending_q;
    cnt_d         = cnt_q + 32'd1;
    note_state_d  = note_state_q;
    note_played_d = note_played_q;
    done_d        = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (grant_valid) begin
          pending_d[grant_idx] = 1'b0;
          note_state_d         = {1'b0, grant_idx} + 4'd1;
          note_played_d        = 3'd1;
        end
      end
      PLAY: begin
        if (note_last) begin
          cnt_d = '0;
          if (note_played_q == 3'd4) note_played_d = 3'd0;
          else                       note_played_d = note_played_q + 3'd1;
        end
      end
      GAP: begin
        if (gap_last) begin
          cnt_d        = '0;
          note_state_d = 4'd0;
          done_d       = 1'b1;
        end
      end
      default: begin
        cnt_d = '0;
      end
    endcase

    // A new request in the same cycle as its grant stays pending, which is
    // what makes a mid-melody repeat queue exactly one replay.
    pending_d = pending_d | req;

    busy_d = (state_d != IDLE);

    // Flush wins over everything, including a simultaneous req and a done.
    if (clear) begin
      pending_d     = '0;
      cnt_d         = '0;
      note_state_d  = 4'd0;
      note_played_d = 3'd0;
      done_d        = 1'b0;
      busy_d        = 1'b0;
    end
  end

  assign note_state  = note_state_q;
  assign note_played = note_played_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_piezo_sequencer.sv
// tb_piezo_sequencer
//   Directed bench for piezo_sequencer with NOTE_CYCLES=4, GAP_CYCLES=2.
//   Inputs change 1 ns after a rising edge; outputs are sampled at that
//   same point, well away from the next edge.

module tb_piezo_sequencer;

  localparam int NOTE = 4;
  localparam int GAP  = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] req;
  logic       clear;
  logic [3:0] note_state;
  logic [2:0] note_played;
  logic       busy;
  logic       done;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  piezo_sequencer #(
    .NOTE_CYCLES(NOTE),
    .GAP_CYCLES (GAP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .clear      (clear),
    .note_state (note_state),
    .note_played(note_played),
    .busy       (busy),
    .done       (done)
  );

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Packed view of all outputs: {note_state, note_played, busy, done}.
  function automatic logic [31:0] outs();
    return {23'd0, note_state, note_played, busy, done};
  endfunction

  function automatic logic [31:0] pack(input logic [3:0] st, input logic [2:0] np,
                                       input logic b, input logic d);
    return {23'd0, st, np, b, d};
  endfunction

  // Holds req/clear for exactly one sampling edge.
  task automatic applyStimulus(input logic [6:0] r, input logic c);
    req   = r;
    clear = c;
    tick();
    req   = '0;
    clear = 1'b0;
  endtask

  // Walks one full melody starting at the grant edge and ending on the done
  // cycle. 'inject' is pulsed on req during the first cycle of note 3.
  task automatic playMelody(input logic [3:0] code, input logic [6:0] inject);
    for (int n = 1; n <= 4; n++) begin
      for (int c = 0; c < NOTE; c++) begin
        tick();
        req = '0;
        checkOutput($sformatf("code%0d_note%0d_cyc%0d", code, n, c), outs(),
                    pack(code, 3'(n), 1'b1, 1'b0));
        if (n == 3 && c == 0) req = inject;
      end
    end
    for (int g = 0; g < GAP; g++) begin
      tick();
      checkOutput($sformatf("code%0d_gap%0d", code, g), outs(), pack(code, 3'd0, 1'b1, 1'b0));
    end
    tick();
    checkOutput($sformatf("code%0d_done", code), outs(), pack(4'd0, 3'd0, 1'b0, 1'b1));
  endtask

  initial begin
    logic [31:0] seen;

    rst   = 1'b1;
    req   = '0;
    clear = 1'b0;

    // Reset held with requests toggling: nothing may be captured.
    #2 rst = 1'b0;
    #1 checkOutput("reset_async", outs(), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      req = (i % 2 == 0) ? 7'h7F : 7'h00;
      checkOutput($sformatf("reset_hold%0d", i), outs(), 32'd0);
    end
    tick();
    req = '0;
    rst = 1'b1;
    seen = '0;
    for (int i = 0; i < 6; i++) begin
      tick();
      seen |= outs();
    end
    checkOutput("reset_release_quiet", seen, 32'd0);

    // Single melody, code 1.
    applyStimulus(7'h01, 1'b0);
    checkOutput("single_latency_pre", outs(), 32'd0);
    playMelody(4'd1, 7'h00);
    tick();
    checkOutput("single_after", outs(), 32'd0);

    // Simultaneous requests: code 2 then code 5, one idle cycle between.
    applyStimulus(7'h12, 1'b0);
    playMelody(4'd2, 7'h00);
    playMelody(4'd5, 7'h00);
    tick();
    checkOutput("simul_after", outs(), 32'd0);

    // Requeue: product 1 again while its own melody is on note 3.
    applyStimulus(7'h08, 1'b0);
    playMelody(4'd4, 7'h08);
    playMelody(4'd4, 7'h00);
    tick();
    checkOutput("requeue_after", outs(), 32'd0);

    // Clear during note 2, together with a new request.
    applyStimulus(7'h40, 1'b0);
    for (int i = 0; i < NOTE + 1; i++) tick();
    checkOutput("clear_pre", outs(), pack(4'd7, 3'd2, 1'b1, 1'b0));
    applyStimulus(7'h40, 1'b1);
    checkOutput("clear_now", outs(), 32'd0);
    seen = '0;
    for (int i = 0; i < 25; i++) begin
      tick();
      seen |= outs();
    end
    checkOutput("clear_quiet", seen, 32'd0);

    // Asynchronous reset mid-gap with another request pending.
    applyStimulus(7'h01, 1'b0);
    for (int i = 0; i < 4 * NOTE; i++) begin
      tick();
      req = (i == 5) ? 7'h04 : 7'h00;
    end
    req = '0;
    tick();
    checkOutput("areset_in_gap", outs(), pack(4'd1, 3'd0, 1'b1, 1'b0));
    #2 rst = 1'b0;
    #1 checkOutput("areset_immediate", outs(), 32'd0);
    tick();
    tick();
    rst = 1'b1;
    seen = '0;
    for (int i = 0; i < 25; i++) begin
      tick();
      seen |= outs();
    end
    checkOutput("areset_quiet", seen, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
